// File: rtl/pipe_credit_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_credit_fifo : credit-gated catch buffer behind a non-stallable pipeline
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipe_credit_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          ISSUE_VALID,
  output logic          ISSUE_READY,
  input  logic          RES_VALID,
  input  logic [W-1:0]  RES_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [W-1:0]  OUT_DATA,
  output logic [CW-1:0] CREDITS,
  output logic          OVF_ERR
);

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [PW-1:0] C_LAST  = PW'(DEPTH - 1);

  logic [CW-1:0] cr_q,  cr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wp_q,  wp_d;
  logic [PW-1:0] rp_q,  rp_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  mem_q [DEPTH];

  logic w_issue;
  logic w_pop;
  logic w_full;
  logic w_push;
  logic w_drop;

  assign w_issue = ISSUE_VALID && (cr_q != '0);
  assign w_pop   = OUT_READY && (cnt_q != '0);
  assign w_full  = (cnt_q == C_DEPTH);
  // A full buffer still accepts a result when the head leaves in the same cycle.
  assign w_push  = RES_VALID && (!w_full || w_pop);
  assign w_drop  = RES_VALID && w_full && !w_pop;

  always_comb begin
    cr_d  = cr_q;
    cnt_d = cnt_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    ovf_d = ovf_q || w_drop;

    case ({w_issue, w_pop})
      2'b10:   cr_d = cr_q - CW'(1);
      2'b01:   cr_d = cr_q + CW'(1);
      default: cr_d = cr_q;
    endcase

    case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (w_push) begin
      wp_d = (wp_q == C_LAST) ? '0 : wp_q + PW'(1);
    end
    if (w_pop) begin
      rp_d = (rp_q == C_LAST) ? '0 : rp_q + PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cr_q  <= C_DEPTH;
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cr_q  <= cr_d;
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovf_q <= ovf_d;
      if (w_push) begin
        mem_q[wp_q] <= RES_DATA;
      end
    end
  end

  assign ISSUE_READY = (cr_q != '0);
  assign OUT_VALID   = (cnt_q != '0);
  assign OUT_DATA    = mem_q[rp_q];
  assign CREDITS     = cr_q;
  assign OVF_ERR     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_credit_fifo.sv
`default_nettype none
// Bench for pipe_credit_fifo: three depths (4, 3, 2), an L=3 pipeline model and
// a queue-based reference model compared against the selected instance every cycle.
module tb_pipe_credit_fifo;

  localparam int NI = 3;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [NI-1:0]      rstn;
  logic [NI-1:0]      iss_v;
  logic [NI-1:0]      res_v;
  logic [NI-1:0][7:0] res_d;
  logic [NI-1:0]      out_r;
  wire  [NI-1:0]      iss_r;
  wire  [NI-1:0]      out_v;
  wire  [NI-1:0][7:0] out_d;
  wire  [NI-1:0][2:0] cred;
  wire  [NI-1:0]      ovf;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D = (g == 0) ? 4 : (g == 1) ? 3 : 2;
    wire [$clog2(D+1)-1:0] cr_w;
    pipe_credit_fifo #(.W(8), .DEPTH(D)) u_dut (
      .CLK         (CLK),
      .RSTN        (rstn[g]),
      .ISSUE_VALID (iss_v[g]),
      .ISSUE_READY (iss_r[g]),
      .RES_VALID   (res_v[g]),
      .RES_DATA    (res_d[g]),
      .OUT_VALID   (out_v[g]),
      .OUT_READY   (out_r[g]),
      .OUT_DATA    (out_d[g]),
      .CREDITS     (cr_w),
      .OVF_ERR     (ovf[g])
    );
    assign cred[g] = 3'(cr_w);
  end

  int total = 0;
  int bad   = 0;

  int         sel;
  int         md;
  int         m_cr;
  logic [7:0] q [$];
  bit         m_ovf;
  bit         pv [3];
  logic [7:0] pd [3];
  bit         forced;
  logic [7:0] next_data;
  logic [7:0] exp_pop;
  logic [7:0] last_dout;
  int         pops;
  int         issued;

  function automatic int depth_of(input int g);
    return (g == 0) ? 4 : (g == 1) ? 3 : 2;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int inflight();
    return int'(pv[0]) + int'(pv[1]) + int'(pv[2]);
  endfunction

  task automatic model_reset();
    m_cr  = md;
    q     = {};
    m_ovf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pd[i] = 8'h00;
    end
  endtask

  // Reference behaviour for one rising edge, from the FIFO/credit rules.
  task automatic model_edge();
    bit issue, pop, push;
    issue = iss_v[sel] && (m_cr != 0);
    pop   = out_r[sel] && (q.size() != 0);
    push  = res_v[sel];
    if (pop && !forced) begin
      check("pop order", int'(last_dout), int'(exp_pop));
      exp_pop++;
    end
    if (pop) pops++;
    if (issue) begin
      m_cr--;
      issued++;
    end
    if (pop) m_cr++;
    if (push && q.size() == md && !pop) begin
      m_ovf = 1'b1;
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(res_d[sel]);
    end
    pv[2] = pv[1]; pd[2] = pd[1];
    pv[1] = pv[0]; pd[1] = pd[0];
    pv[0] = issue; pd[0] = next_data;
    if (issue) next_data++;
  endtask

  task automatic compare_outputs();
    check("ISSUE_READY", int'(iss_r[sel]), int'(m_cr != 0));
    check("CREDITS",     int'(cred[sel]),  m_cr);
    check("OUT_VALID",   int'(out_v[sel]), int'(q.size() != 0));
    if (q.size() != 0) check("OUT_DATA", int'(out_d[sel]), int'(q[0]));
    check("OVF_ERR",     int'(ovf[sel]),   int'(m_ovf));
    if (!forced) check("credit invariant", int'(cred[sel]) + q.size() + inflight(), md);
    last_dout = out_d[sel];
  endtask

  task automatic step();
    @(posedge CLK);
    if (rstn[sel]) model_edge();
    @(negedge CLK);
    if (!forced) begin
      res_v[sel] = pv[2];
      res_d[sel] = pv[2] ? pd[2] : 8'h00;
    end
    compare_outputs();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ISSUE_READY"}, int'(iss_r[sel]), 1);
    check({tag, " OUT_VALID"},   int'(out_v[sel]), 0);
    check({tag, " OUT_DATA"},    int'(out_d[sel]), 0);
    check({tag, " CREDITS"},     int'(cred[sel]),  md);
    check({tag, " OVF_ERR"},     int'(ovf[sel]),   0);
  endtask

  task automatic reset_dut(input int g);
    sel    = g;
    md     = depth_of(g);
    forced = 1'b0;
    model_reset();
    @(negedge CLK);
    rstn[g] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      iss_v[g] = 1'($urandom_range(0, 1));
      out_r[g] = 1'($urandom_range(0, 1));
      res_v[g] = 1'($urandom_range(0, 1));
      res_d[g] = 8'($urandom_range(0, 255));
      @(negedge CLK);
      check_reset_vals("reset");
    end
    iss_v[g] = 1'b0;
    out_r[g] = 1'b0;
    res_v[g] = 1'b0;
    res_d[g] = 8'h00;
    rstn[g]  = 1'b1;
    issued   = 0;
    pops     = 0;
  endtask

  initial begin
    int cycles;
    rstn  = '0;
    iss_v = '0;
    res_v = '0;
    res_d = '0;
    out_r = '0;
    sel = 0; md = 4; forced = 1'b0;
    next_data = 8'h00; exp_pop = 8'h00; last_dout = 8'h00;
    pops = 0; issued = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    rstn = '1;

    // Single item: issue 0xA5, visible four cycles later, credit returns after pop.
    reset_dut(0);
    out_r[0]  = 1'b1;
    next_data = 8'hA5;
    exp_pop   = 8'hA5;
    iss_v[0]  = 1'b1;
    step();
    iss_v[0] = 1'b0;
    check("single credits after issue", int'(cred[0]), 3);
    step();
    step();
    check("single not yet valid c3", int'(out_v[0]), 0);
    step();
    check("single valid c4", int'(out_v[0]), 1);
    check("single data c4", int'(out_d[0]), 8'hA5);
    check("single credits c4", int'(cred[0]), 3);
    step();
    check("single credits back", int'(cred[0]), 4);
    check("single empty after pop", int'(out_v[0]), 0);

    // Backpressure: only DEPTH issues accepted, then drain in order.
    reset_dut(0);
    next_data = 8'h01;
    exp_pop   = 8'h01;
    iss_v[0]  = 1'b1;
    repeat (10) step();
    check("bp accepted issues", issued, 4);
    check("bp ISSUE_READY low", int'(iss_r[0]), 0);
    check("bp credits zero", int'(cred[0]), 0);
    check("bp head", int'(out_d[0]), 1);
    check("bp no overflow", int'(ovf[0]), 0);
    iss_v[0] = 1'b0;
    out_r[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("bp drain data", int'(out_d[0]), k);
      step();
    end
    check("bp drained", int'(out_v[0]), 0);
    check("bp credits restored", int'(cred[0]), 4);

    // Full buffer, then stream 64 items with both sides always active.
    reset_dut(0);
    next_data = 8'h01;
    exp_pop   = 8'h01;
    iss_v[0]  = 1'b1;
    repeat (7) step();
    check("stream full credits", int'(cred[0]), 0);
    check("stream full valid", int'(out_v[0]), 1);
    out_r[0] = 1'b1;
    pops   = 0;
    cycles = 0;
    while (pops < 64 && cycles < 400) begin
      step();
      cycles++;
    end
    check("stream pops", pops, 64);
    check("stream next expected", int'(exp_pop), 65);
    check("stream no overflow", int'(ovf[0]), 0);

    // Non-power-of-two depth with random consumer stalls across pointer wrap.
    reset_dut(1);
    next_data = 8'h01;
    exp_pop   = 8'h01;
    cycles    = 0;
    while (pops < 20 && cycles < 400) begin
      iss_v[1] = (next_data <= 8'd20);
      out_r[1] = 1'($urandom_range(0, 1));
      step();
      cycles++;
    end
    check("wrap pops", pops, 20);
    check("wrap issued", issued, 20);
    iss_v[1] = 1'b0;
    out_r[1] = 1'b0;
    step();
    check("wrap credits restored", int'(cred[1]), 3);
    check("wrap empty", int'(out_v[1]), 0);

    // Overflow with directly driven results, then asynchronous reset mid-stream.
    reset_dut(2);
    forced   = 1'b1;
    iss_v[2] = 1'b1;
    step();
    step();
    iss_v[2] = 1'b0;
    check("ovf credits used", int'(cred[2]), 0);
    check("ovf ISSUE_READY low", int'(iss_r[2]), 0);
    res_v[2] = 1'b1; res_d[2] = 8'h11;
    step();
    res_d[2] = 8'h22;
    step();
    check("ovf full head", int'(out_d[2]), 8'h11);
    out_r[2] = 1'b1; res_d[2] = 8'h33;
    step();
    check("full push+pop no ovf", int'(ovf[2]), 0);
    check("full push+pop head", int'(out_d[2]), 8'h22);
    check("full push+pop credits", int'(cred[2]), 1);
    out_r[2] = 1'b0; res_d[2] = 8'h44;
    step();
    check("ovf flag set", int'(ovf[2]), 1);
    check("ovf head kept", int'(out_d[2]), 8'h22);
    res_v[2] = 1'b0; out_r[2] = 1'b1;
    step();
    check("ovf dropped value skipped", int'(out_d[2]), 8'h33);
    check("ovf sticky", int'(ovf[2]), 1);
    res_v[2] = 1'b1; res_d[2] = 8'h55; out_r[2] = 1'b0;
    step();
    check("ovf still sticky", int'(ovf[2]), 1);
    #2;
    rstn[2] = 1'b0;
    #1;
    check_reset_vals("mid reset");
    model_reset();
    res_v[2] = 1'b0;
    step();
    step();
    rstn[2] = 1'b1;
    step();
    check("post reset ovf", int'(ovf[2]), 0);
    check("post reset credits", int'(cred[2]), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
